// File: rtl/fp32_mult_sched.sv
// fp32_mult_sched: shares one fixed-latency FP32 multiplier among N requesters.
// Round-robin picks at most one operand pair per cycle. A {valid, id} tag rides
// alongside the multiplier so each product lands in its requester's result slot.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. req_ready is derived only from req_valid, the busy bits and the
// round-robin pointer; it never looks at rsp_ready. rsp_valid/rsp_data hold
// until the edge on which rsp_ready is sampled high.
module fp32_mult_sched #(
    parameter int N   = 4,
    parameter int LAT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    output logic [N-1:0]      rsp_valid,
    input  logic [N-1:0]      rsp_ready,
    output logic [32*N-1:0]   rsp_data,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_y,
    output logic              idle,
    output logic [15:0]       issue_count
);

    localparam int IDW = $clog2(N);

    // One outstanding operation per requester; set on accept, cleared on result pickup.
    logic [N-1:0]   busy;
    logic [IDW-1:0] last_grant;

    logic [N-1:0]   eligible;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           accept;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;

    // Tag pipeline: stage k is valid k+1 cycles after the accept edge, so
    // stage LAT lines up with mul_y for the same operand pair.
    logic           tag_v  [LAT+1];
    logic [IDW-1:0] tag_id [LAT+1];

    logic [N-1:0]   capture;
    logic [N-1:0]   rsp_done;

    assign eligible = req_valid & ~busy;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(last_grant) + 1 + k) % N);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

    assign req_ready = rstn ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    // Issue stage: register operands toward the multiplier, advance pointer and count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mul_a       <= '0;
            mul_b       <= '0;
            last_grant  <= IDW'(N - 1);
            issue_count <= '0;
        end else if (accept) begin
            mul_a       <= sel_a;
            mul_b       <= sel_b;
            last_grant  <= grant_id;
            issue_count <= issue_count + 16'd1;
        end else begin
            mul_a       <= '0;
            mul_b       <= '0;
        end
    end

    // Tag pipeline shifts every cycle; the multiplier itself has no stall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k <= LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= accept;
            tag_id[0] <= grant_id;
            for (int k = 1; k <= LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Decode which result slot the product arriving this cycle belongs to.
    always_comb begin
        capture = '0;
        for (int i = 0; i < N; i++) begin
            capture[i] = tag_v[LAT] && (tag_id[LAT] == IDW'(i));
        end
    end

    assign rsp_done = rsp_valid & rsp_ready;

    // Result slots and busy bits; the busy rule guarantees a slot is empty on capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (capture[i]) begin
                    rsp_valid[i]          <= 1'b1;
                    rsp_data[32*i +: 32]  <= mul_y;
                end else if (rsp_done[i]) begin
                    rsp_valid[i]          <= 1'b0;
                end
                if (accept && grant[i]) begin
                    busy[i] <= 1'b1;
                end else if (rsp_done[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign idle = ~|busy;

endmodule

// File: doc/fp32_mult_sched.md
FP32_MULT_SCHED -- requirements
Module: fp32_mult_sched

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one multiplier; range 2..8.
REQ-002 Parameter LAT, default 4: fixed multiplier latency in cycles; range 1..8.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rstn  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  N  per-requester operand-pair valid.
REQ-006 req_ready  out  N  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  in  32*N  operand A, requester i at bits [32i+31:32i].
REQ-008 req_b  in  32*N  operand B, same packing.
REQ-009 rsp_valid  out  N  per-requester result valid.
REQ-010 rsp_ready  in  N  per-requester result accept.
REQ-011 rsp_data  out  32*N  per-requester result, same packing.
REQ-012 mul_a  out  32  registered operand A to the shared multiplier.
REQ-013 mul_b  out  32  registered operand B to the shared multiplier.
REQ-014 mul_y  in  32  multiplier product, valid LAT cycles after mul_a/mul_b change; multiplier has no enable or valid.
REQ-015 idle  out  1  high when no operation is in flight and no result is held.
REQ-016 issue_count  out  16  count of accepted requests, wraps 0xFFFF -> 0x0000.

Function
REQ-017 Per-requester busy bit: set on accept, cleared on rsp_valid & rsp_ready handshake; max one outstanding operation per requester.
REQ-018 Eligible(i) = req_valid[i] & ~busy[i]; req_ready[i] is combinational from eligible vector and priority pointer only, never from rsp_ready.
REQ-019 Round-robin arbitration: search order starts at (last_grant+1) mod N; first eligible requester gets req_ready; last_grant updates only on an accept.
REQ-020 At most one accept per cycle; accept = req_valid[i] & req_ready[i].
REQ-021 On accept edge: mul_a/mul_b <= selected req_a/req_b; tag pipeline stage 0 <= {valid=1, id=i}; otherwise mul_a/mul_b <= 0 and stage 0 valid <= 0.
REQ-022 Tag pipeline: LAT+1 stages of {valid, id}, shifting every cycle unconditionally; stage LAT aligns with mul_y for that operand pair.
REQ-023 When stage LAT valid: at next edge rsp_data[id] <= mul_y, rsp_valid[id] <= 1.
REQ-024 Latency: accept in cycle c -> rsp_valid[i] high from cycle c+LAT+2; fully pipelined, one accept per cycle sustained across distinct requesters.
REQ-025 rsp_valid[i] and rsp_data[i] hold stable until rsp_ready[i] sampled high; on handshake edge rsp_valid[i] <= 0 and busy[i] <= 0.
REQ-026 Requester whose busy clears at edge E is eligible from the cycle after E, not earlier.
REQ-027 Result capture and consumer handshake for different requesters in same cycle: both take effect independently.
REQ-028 No back-pressure on multiplier required: busy rule guarantees rsp slot i is empty when its result arrives.
REQ-029 idle = ~|busy; issue_count increments by 1 on every accept edge.
REQ-030 Data passes through unmodified; no inspection of NaN/Inf/zero encodings.

Reset
REQ-031 While rstn low at an edge: busy <= 0, rsp_valid <= 0, rsp_data <= 0, all tag stages invalid, mul_a/mul_b <= 0, issue_count <= 0, last_grant <= N-1.
REQ-032 req_ready is 0 during any cycle where rstn is low.
REQ-033 Reset mid-operation: in-flight operations discarded; no rsp_valid for them after reset release; first post-reset grant goes to lowest-index eligible requester.

Verification (bench uses LAT-delay stub multiplier returning mul_a + mul_b integer sum, so result-to-requester routing is checkable)
REQ-034 Single request: req 0 a=0x00000002 b=0x00000003 accepted cycle 0 -> rsp_valid[0] cycle 6 (LAT=4), rsp_data[0]=0x00000005, idle=0 cycles 1..handshake.
REQ-035 All four req_valid high, rsp_ready tied high, a=i, b=0x100 -> grants in order 0,1,2,3 on consecutive cycles; results 0x100..0x103 on cycles 6..9 to matching ports.
REQ-036 Back-pressure: rsp_ready[1]=0 after first result -> req_ready[1] stays 0 with req_valid[1] high; others continue round-robin; rsp_ready[1] high cycle k -> req_ready[1] possible from k+1.
REQ-037 Reset at cycle 3 with 3 operations in flight -> no rsp_valid ever rises for them; issue_count=0; post-release grant order starts at requester 0.
REQ-038 Issue_count preloaded by 65536 accepts (forced) -> wraps to 0x0000 with no other side effect; LAT=1 and N=8 parameter sweep repeats REQ-035 pattern with latency LAT+2.
